sensor_conditioner: RTL and testbench
=====================================

SENSOR_CONDITIONER -- requirements
Module: sensor_conditioner

Interface
REQ-001 Parameter TICK_DIV, default 1000, meaning: Clk cycles per debounce sample tick (range 2..65535).
REQ-002 Parameter DEB_TICKS, default 8, meaning: consecutive differing ticks required before a conditioned output changes (range 1..255).
REQ-003 Parameter FAULT_TICKS, default 16, meaning: ticks that the Bs/Vs conflict must persist before a fault is declared (range 1..255).
REQ-004 Clk  input  1  single system clock; all state is on its rising edge.
REQ-005 Rst  input  1  reset, asynchronous and active-high.
REQ-006 Us_raw  input  1  raw soil-humidity sensor, asynchronous to Clk.
REQ-007 Bs_raw  input  1  raw Bs mode switch, asynchronous to Clk.
REQ-008 Vs_raw  input  1  raw Vs mode switch, asynchronous to Clk.
REQ-009 Adub_raw  input  1  raw fertiliser-request input, asynchronous to Clk.
REQ-010 Us, Bs, Vs, Adub  output  1 each  conditioned levels that feed the irrigation controller top.
REQ-011 Err  output  1  Bs/Vs conflict fault flag.
REQ-012 Chg  output  1  one-cycle pulse when any of Us, Bs, Vs, Adub or Err changes.

Function
REQ-013 Each raw input SHALL pass through a two-flop synchronizer before any other logic.
REQ-014 A prescaler counting 0..TICK_DIV-1 SHALL emit a one-Clk tick on wrap; the first tick occurs TICK_DIV cycles after reset release.
REQ-015 Per channel, on each tick: if the synchronized sample differs from the stable level, the channel counter increments; otherwise the counter clears to 0.
REQ-016 When the channel counter reaches DEB_TICKS, the stable level SHALL toggle and the counter SHALL clear in the same cycle.
REQ-017 A glitch shorter than DEB_TICKS ticks SHALL never reach an output; worst-case latency = 2 + DEB_TICKS*TICK_DIV Clk cycles.
REQ-018 Us and Adub outputs SHALL equal their stable levels, registered, with no additional delay.
REQ-019 Conflict FSM states: OK, PEND, FAULT.
REQ-020 In OK: if the stable Bs and stable Vs are both 1, go to PEND and clear the fault counter.
REQ-021 In PEND: on each tick with both still 1, increment the fault counter; when it reaches FAULT_TICKS, go to FAULT; if either becomes 0, return to OK.
REQ-022 In FAULT: Err=1 and Bs=Vs=0 are forced; return to OK only when the stable Bs and stable Vs are both 0.
REQ-023 In OK and PEND, Bs and Vs outputs SHALL equal their stable levels, so a transient conflict is passed through until a fault is declared.
REQ-024 Chg SHALL be 1 for exactly one cycle after any output register changes; simultaneous changes produce a single pulse.
REQ-025 Counters SHALL saturate and never wrap; the counter width is the minimum needed for the parameter range.

Reset
REQ-026 Rst SHALL asynchronously clear synchronizers, prescaler, channel counters and stable levels to 0, set the FSM to OK, and drive Us=Bs=Vs=Adub=Err=Chg=0.
REQ-027 Rst asserted mid-debounce or in FAULT SHALL discard all progress; after release, an input held at 1 requires the full latency again.

Structure
REQ-028 The FSM state encoding and the default values of TICK_DIV, DEB_TICKS and FAULT_TICKS SHALL live in the shared irrigation package.
REQ-029 One sub-module, debounce_ch (sync + counter + stable level, parameterised by DEB_TICKS), SHALL be instantiated four times; the prescaler, FSM and Chg logic stay in the top.

Verification (TICK_DIV=4, DEB_TICKS=3, FAULT_TICKS=2)
REQ-030 Step Us_raw 0->1 after reset and hold -> Us rises after at most 2+12 cycles, with a Chg pulse in the following cycle.
REQ-031 Us_raw pulses high for 2 ticks (8 cycles) then low -> Us stays 0 and Chg stays 0.
REQ-032 Drive Bs_raw=Vs_raw=1 -> Bs and Vs rise; 2 ticks later Err=1 and Bs=Vs=0; drop both raws -> after debounce, Err=0.
REQ-033 Bs and Vs high for 1 tick, then Vs_raw drops -> FSM returns to OK and Err never asserts.
REQ-034 Assert Rst in FAULT and mid-debounce -> all outputs are 0 immediately; after release, the full latency is required again.
REQ-035 Toggle all four raws in the same cycle -> all outputs change in the same cycle, with exactly one Chg pulse.

Source files
------------

// File: rtl/irrigation_pkg.sv
// Shared irrigation definitions: parameter defaults, counter widths,
// channel indices and the Bs/Vs conflict FSM encoding.
package irrigation_pkg;

  localparam int unsigned TICK_DIV_DEF    = 1000;
  localparam int unsigned DEB_TICKS_DEF   = 8;
  localparam int unsigned FAULT_TICKS_DEF = 16;

  // Widths sized for the full legal parameter ranges (65535 / 255 / 255)
  localparam int unsigned PRE_W   = 16;
  localparam int unsigned DEB_W   = 8;
  localparam int unsigned FAULT_W = 8;

  localparam int unsigned N_CH    = 4;
  localparam int unsigned CH_US   = 3;
  localparam int unsigned CH_BS   = 2;
  localparam int unsigned CH_VS   = 1;
  localparam int unsigned CH_ADUB = 0;

  typedef enum logic [1:0] {
    CONF_OK    = 2'd0,
    CONF_PEND  = 2'd1,
    CONF_FAULT = 2'd2
  } conf_state_e;

  typedef struct packed {
    logic us;
    logic bs;
    logic vs;
    logic adub;
    logic err;
  } cond_out_t;

endpackage

// File: rtl/debounce_ch.sv
// One sensor channel: two-flop synchronizer followed by a tick-based
// debouncer that toggles its stable level after DEB_TICKS differing ticks.
module debounce_ch
  import irrigation_pkg::*;
#(
  parameter int unsigned DEB_TICKS = DEB_TICKS_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic raw,
  output logic level,
  output logic level_nxt_c
);

  logic             sync_q1;
  logic             sync_q2;
  logic [DEB_W-1:0] cnt;
  logic [DEB_W-1:0] cnt_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= raw;
      sync_q2 <= sync_q1;
    end
  end

  // Count differing ticks; the toggle and counter clear share one cycle
  always_comb begin
    level_nxt_c = level;
    cnt_nxt     = cnt;
    if (tick) begin
      if (sync_q2 != level) begin
        if (cnt >= DEB_W'(DEB_TICKS - 1)) begin
          level_nxt_c = ~level;
          cnt_nxt     = '0;
        end else begin
          cnt_nxt = cnt + DEB_W'(1);
        end
      end else begin
        cnt_nxt = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level <= 1'b0;
      cnt   <= '0;
    end else begin
      level <= level_nxt_c;
      cnt   <= cnt_nxt;
    end
  end

endmodule

// File: rtl/sensor_conditioner.sv
// Conditions the four raw irrigation inputs: shared tick prescaler, four
// debounced channels, Bs/Vs conflict fault FSM and a change pulse.
module sensor_conditioner
  import irrigation_pkg::*;
#(
  parameter int unsigned TICK_DIV    = TICK_DIV_DEF,
  parameter int unsigned DEB_TICKS   = DEB_TICKS_DEF,
  parameter int unsigned FAULT_TICKS = FAULT_TICKS_DEF
) (
  input  logic Clk,
  input  logic Rst,
  input  logic Us_raw,
  input  logic Bs_raw,
  input  logic Vs_raw,
  input  logic Adub_raw,
  output logic Us,
  output logic Bs,
  output logic Vs,
  output logic Adub,
  output logic Err,
  output logic Chg
);

  logic [PRE_W-1:0]   pre_cnt;
  logic               tick_c;
  logic [N_CH-1:0]    raw_vec;
  logic [N_CH-1:0]    lvl;
  logic [N_CH-1:0]    lvl_nxt;
  conf_state_e        state;
  conf_state_e        state_nxt;
  logic [FAULT_W-1:0] fcnt;
  logic [FAULT_W-1:0] fcnt_nxt;
  logic               conflict_c;
  logic               bs_q;
  logic               vs_q;
  logic               err_q;
  logic               chg_q;
  cond_out_t          out_cur;
  cond_out_t          out_prev;

  assign tick_c = (pre_cnt == PRE_W'(TICK_DIV - 1));

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      pre_cnt <= '0;
    end else if (tick_c) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + PRE_W'(1);
    end
  end

  assign raw_vec[CH_US]   = Us_raw;
  assign raw_vec[CH_BS]   = Bs_raw;
  assign raw_vec[CH_VS]   = Vs_raw;
  assign raw_vec[CH_ADUB] = Adub_raw;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_ch #(
      .DEB_TICKS(DEB_TICKS)
    ) u_ch (
      .clk        (Clk),
      .rst        (Rst),
      .tick       (tick_c),
      .raw        (raw_vec[i]),
      .level      (lvl[i]),
      .level_nxt_c(lvl_nxt[i])
    );
  end

  assign conflict_c = lvl[CH_BS] & lvl[CH_VS];

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state <= CONF_OK;
      fcnt  <= '0;
    end else begin
      state <= state_nxt;
      fcnt  <= fcnt_nxt;
    end
  end

  // Conflict must persist FAULT_TICKS ticks; counter parks at its limit
  always_comb begin
    state_nxt = state;
    fcnt_nxt  = fcnt;
    unique case (state)
      CONF_OK: begin
        if (conflict_c) begin
          state_nxt = CONF_PEND;
          fcnt_nxt  = '0;
        end
      end
      CONF_PEND: begin
        if (!conflict_c) begin
          state_nxt = CONF_OK;
        end else if (tick_c) begin
          if (fcnt >= FAULT_W'(FAULT_TICKS - 1)) begin
            state_nxt = CONF_FAULT;
            fcnt_nxt  = FAULT_W'(FAULT_TICKS);
          end else begin
            fcnt_nxt = fcnt + FAULT_W'(1);
          end
        end
      end
      CONF_FAULT: begin
        if (!lvl[CH_BS] && !lvl[CH_VS]) begin
          state_nxt = CONF_OK;
        end
      end
      default: state_nxt = CONF_OK;
    endcase
  end

  // Built from next-state values so Bs/Vs move in the same cycle as Us/Adub
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      bs_q  <= 1'b0;
      vs_q  <= 1'b0;
      err_q <= 1'b0;
    end else begin
      bs_q  <= lvl_nxt[CH_BS] && (state_nxt != CONF_FAULT);
      vs_q  <= lvl_nxt[CH_VS] && (state_nxt != CONF_FAULT);
      err_q <= (state_nxt == CONF_FAULT);
    end
  end

  assign out_cur = '{us: lvl[CH_US], bs: bs_q, vs: vs_q, adub: lvl[CH_ADUB], err: err_q};

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      out_prev <= '0;
      chg_q    <= 1'b0;
    end else begin
      out_prev <= out_cur;
      chg_q    <= (out_cur != out_prev);
    end
  end

  assign Us   = lvl[CH_US];
  assign Adub = lvl[CH_ADUB];
  assign Bs   = bs_q;
  assign Vs   = vs_q;
  assign Err  = err_q;
  assign Chg  = chg_q;

endmodule

// File: tb/tb_sensor_conditioner.sv
// Bench for sensor_conditioner: vector table, corner-case sequences and
// random stimulus against a tick-level behavioural model.
`timescale 1ns/1ps
module tb_sensor_conditioner;

  localparam int TD  = 4;
  localparam int DT  = 3;
  localparam int FT  = 2;
  localparam int FT2 = 6;
  localparam int M_OK    = 0;
  localparam int M_PEND  = 1;
  localparam int M_FAULT = 2;

  logic       Clk = 1'b0;
  logic       Rst;
  logic [3:0] raws;   // {Us, Bs, Vs, Adub}
  logic [1:0] raws2;  // {Bs, Vs} of the second instance
  logic       Us, Bs, Vs, Adub, Err, Chg;
  logic       Us2, Bs2, Vs2, Adub2, Err2, Chg2;
  logic [5:0] out6, out6_2;
  int         total = 0;
  int         bad   = 0;

  always #5 Clk = ~Clk;

  sensor_conditioner #(.TICK_DIV(TD), .DEB_TICKS(DT), .FAULT_TICKS(FT)) u_dut (
    .Clk(Clk), .Rst(Rst),
    .Us_raw(raws[3]), .Bs_raw(raws[2]), .Vs_raw(raws[1]), .Adub_raw(raws[0]),
    .Us(Us), .Bs(Bs), .Vs(Vs), .Adub(Adub), .Err(Err), .Chg(Chg)
  );

  // Longer fault window so a conflict can clear before being declared
  sensor_conditioner #(.TICK_DIV(TD), .DEB_TICKS(DT), .FAULT_TICKS(FT2)) u_dut2 (
    .Clk(Clk), .Rst(Rst),
    .Us_raw(1'b0), .Bs_raw(raws2[1]), .Vs_raw(raws2[0]), .Adub_raw(1'b0),
    .Us(Us2), .Bs(Bs2), .Vs(Vs2), .Adub(Adub2), .Err(Err2), .Chg(Chg2)
  );

  assign out6   = {Us, Bs, Vs, Adub, Err, Chg};
  assign out6_2 = {Us2, Bs2, Vs2, Adub2, Err2, Chg2};

  // ---------------- behavioural model of u_dut ----------------
  int         n = 0;
  logic [3:0] hq[$];
  int         run[4];
  logic [3:0] lvl  = '0;
  int         mode = M_OK;
  int         pend = 0;
  logic [4:0] mo   = '0;
  logic [4:0] mp   = '0;
  logic       mchg = 1'b0;

  task automatic model_reset();
    n = 0;
    hq.delete();
    for (int c = 0; c < 4; c++) run[c] = 0;
    lvl  = '0;
    mode = M_OK;
    pend = 0;
    mo   = '0;
    mp   = '0;
    mchg = 1'b0;
  endtask

  task automatic model_step();
    logic [3:0] syn;
    bit tick, both;
    n++;
    tick = (n % TD) == 0;
    syn  = (hq.size() == 2) ? hq[0] : 4'b0;
    hq.push_back(raws);
    if (hq.size() > 2) void'(hq.pop_front());
    both = lvl[2] && lvl[1];
    case (mode)
      M_OK: begin
        if (both) begin mode = M_PEND; pend = 0; end
      end
      M_PEND: begin
        if (!both) mode = M_OK;
        else if (tick) begin
          pend++;
          if (pend == FT) mode = M_FAULT;
        end
      end
      default: begin
        if (!lvl[2] && !lvl[1]) mode = M_OK;
      end
    endcase
    if (tick) begin
      for (int c = 0; c < 4; c++) begin
        if (syn[c] != lvl[c]) begin
          run[c]++;
          if (run[c] == DT) begin
            lvl[c] = ~lvl[c];
            run[c] = 0;
          end
        end else begin
          run[c] = 0;
        end
      end
    end
    mchg = (mo != mp);
    mp   = mo;
    mo   = {lvl[3], lvl[2] && mode != M_FAULT, lvl[1] && mode != M_FAULT, lvl[0], mode == M_FAULT};
  endtask

  always @(posedge Clk or posedge Rst) begin
    if (Rst) model_reset();
    else     model_step();
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [5:0] act, input logic [5:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @%0t: got %b want %b", name, $time, act, exp);
    end
  endtask

  // Advance k edges; each lands 2ns after the edge and is checked against the model
  task automatic step(input int k);
    repeat (k) begin
      @(posedge Clk);
      #2;
      chk("model", out6, {mo, mchg});
    end
  endtask

  // Ends 2ns after an edge with Rst released; that edge is edge 0
  task automatic do_reset();
    Rst   = 1'b1;
    raws  = '0;
    raws2 = '0;
    step(2);
    Rst = 1'b0;
  endtask

  typedef struct {
    logic [3:0] raw;
    int         hold;
    logic [5:0] exp;
  } vec_t;
  vec_t tbl[16];

  bit seen;

  initial begin
    tbl[0]  = '{4'b1000, 11, 6'b000000};
    tbl[1]  = '{4'b1000,  1, 6'b100000};
    tbl[2]  = '{4'b1000,  1, 6'b100001};
    tbl[3]  = '{4'b0001, 10, 6'b100000};
    tbl[4]  = '{4'b0001,  1, 6'b000100};
    tbl[5]  = '{4'b0001,  1, 6'b000101};
    tbl[6]  = '{4'b0100, 14, 6'b010000};
    tbl[7]  = '{4'b0110,  9, 6'b010000};
    tbl[8]  = '{4'b0110,  4, 6'b011000};
    tbl[9]  = '{4'b0110,  1, 6'b011001};
    tbl[10] = '{4'b0110,  3, 6'b011000};
    tbl[11] = '{4'b0110,  4, 6'b000010};
    tbl[12] = '{4'b0110,  1, 6'b000011};
    tbl[13] = '{4'b0000, 11, 6'b000010};
    tbl[14] = '{4'b0000,  1, 6'b000000};
    tbl[15] = '{4'b0000,  1, 6'b000001};

    Rst   = 1'b1;
    raws  = '0;
    raws2 = '0;
    do_reset();
    chk("reset_state", out6, 6'b000000);

    // Vector table
    for (int i = 0; i < 16; i++) begin
      raws = tbl[i].raw;
      step(tbl[i].hold);
      chk($sformatf("tbl[%0d]", i), out6, tbl[i].exp);
    end

    // Step response of Us and the trailing Chg pulse
    do_reset();
    raws = 4'b1000;
    step(11); chk("us_before", {5'b0, Us}, 6'd0);
    step(1);  chk("us_rise", {4'b0, Us, Chg}, 6'b10);
    step(1);  chk("us_chg", {5'b0, Chg}, 6'd1);
    step(1);  chk("us_chg_end", {5'b0, Chg}, 6'd0);

    // Two-tick glitch never reaches an output
    do_reset();
    raws = 4'b1000;
    step(8);
    raws = 4'b0000;
    seen = 1'b0;
    repeat (40) begin
      step(1);
      if (Us || Chg) seen = 1'b1;
    end
    chk("glitch", {5'b0, seen}, 6'd0);

    // Conflict -> fault, reset in fault, conflict again, then clear
    do_reset();
    raws = 4'b0110;
    step(12); chk("conf_rise", {3'b0, Bs, Vs, Err}, 6'b000110);
    step(7);  chk("conf_pend", {3'b0, Bs, Vs, Err}, 6'b000110);
    step(1);  chk("conf_fault", {3'b0, Bs, Vs, Err}, 6'b000001);
    step(1);  chk("fault_chg", {5'b0, Chg}, 6'd1);
    step(1);
    Rst = 1'b1;
    #1;       chk("rst_in_fault", out6, 6'b000000);
    step(2);
    Rst = 1'b0;
    step(11); chk("refault_before", {4'b0, Bs, Vs}, 6'b00);
    step(1);  chk("refault_rise", {4'b0, Bs, Vs}, 6'b11);
    step(8);  chk("refault", {3'b0, Bs, Vs, Err}, 6'b000001);
    raws = 4'b0000;
    step(12); chk("fault_hold", {5'b0, Err}, 6'd1);
    step(1);  chk("fault_clear", {3'b0, Bs, Vs, Err}, 6'b000000);

    // Reset mid-debounce discards progress
    do_reset();
    raws = 4'b1000;
    step(9);
    Rst = 1'b1;
    #1;       chk("rst_mid_deb", out6, 6'b000000);
    step(2);
    Rst = 1'b0;
    step(11); chk("deb_restart", {5'b0, Us}, 6'd0);
    step(1);  chk("deb_full", {5'b0, Us}, 6'd1);

    // Transient conflict clears before the fault window expires
    do_reset();
    raws2 = 2'b11;
    step(16);
    raws2 = 2'b10;
    step(10); chk("transient_pass", out6_2, 6'b011000);
    seen = 1'b0;
    repeat (30) begin
      step(1);
      if (Err2 || Us2 || Adub2) seen = 1'b1;
    end
    chk("transient_no_err", {5'b0, seen}, 6'd0);
    chk("transient_end", out6_2, 6'b010000);

    // All four raws toggle together -> one Chg pulse
    do_reset();
    raws = 4'b1111;
    step(11); chk("all_before", out6, 6'b000000);
    step(1);  chk("all_rise", out6, 6'b111100);
    step(1);  chk("all_chg", out6, 6'b111101);
    step(1);  chk("all_chg_end", out6, 6'b111100);

    // Random stimulus with occasional resets
    do_reset();
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        Rst = 1'b1;
        #1; chk("rand_rst", out6, 6'b000000);
        step(int'($urandom_range(1, 2)));
        Rst = 1'b0;
      end
      raws = 4'($urandom);
      step(int'($urandom_range(1, 24)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
